pc_fetch_control: RTL and testbench

- Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory.
- Drives the byte address the memory registers on every i_clk edge.
- Sequences PC+4, branch and jump redirects, hazard stalls, debug-unit run/step control and halt.
- Produces a flush pulse so the IF/ID register squashes the wrong-path instruction.

---
 rtl/pc_fetch_control.sv | 92 +++++++++
 tb/tb_pc_fetch_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_control.sv
// pc_fetch_control: PC sequencing and fetch control ahead of instruction memory.
// Define PC_CYCLE_COUNT_EN to build the saturating executed-cycle counter.
module pc_fetch_control #(
    parameter int unsigned      NBITS    = 32,
    parameter logic [NBITS-1:0] PC_RESET = '0,
    parameter logic [NBITS-1:0] PC_INC   = 4,
    parameter logic [NBITS-1:0] PC_LIMIT = 60
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_mode_step,
    input  logic             i_step,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [NBITS-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NBITS-1:0] i_jump_target,
    input  logic             i_halt,
    output logic [NBITS-1:0] o_PC,
    output logic [NBITS-1:0] o_PC_plus4,
    output logic             o_fetch_valid,
    output logic             o_flush,
    output logic             o_halted,
    output logic [31:0]      o_cycle_count
);
    typedef enum logic [1:0] {IDLE, RUN, STEP_WAIT, HALTED} state_t;
    state_t           r_state, w_state_next;
    logic [NBITS-1:0] r_pc, r_pc_plus4, w_pc_next, w_target;
    logic             r_flush, r_fetch_valid, r_halted;
    logic             w_flush_next, w_fetch_valid_next;
    logic             w_advance, w_hold, w_redirect, w_illegal;

    // A branch is older than the stalled instruction, so it overrides the stall.
    assign w_advance  = (r_state == RUN) || (r_state == STEP_WAIT && i_step);
    assign w_hold     = i_stall && !i_branch_taken;
    assign w_redirect = i_branch_taken || (!i_stall && i_jump);
    assign w_target   = i_branch_taken ? i_branch_target :
                        w_hold         ? r_pc :
                        i_jump         ? i_jump_target : r_pc + PC_INC;
    assign w_illegal  = (w_target >= PC_LIMIT) || ((w_target % PC_INC) != '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = (r_state == IDLE && i_start) ? (i_mode_step ? STEP_WAIT : RUN) :
                       (w_advance && (i_halt || w_illegal)) ? HALTED : r_state;
    end

    always_comb begin
        w_pc_next          = (w_advance && !i_halt && !w_illegal) ? w_target : r_pc;
        w_flush_next       = w_advance && (i_halt || w_redirect);
        w_fetch_valid_next = (r_state == IDLE) ? (i_start && !i_mode_step) :
                             (w_advance && !i_halt && !w_illegal && !w_hold);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc          <= PC_RESET;
            r_pc_plus4    <= PC_RESET + PC_INC;
            r_flush       <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc          <= w_pc_next;
            r_pc_plus4    <= w_pc_next + PC_INC;
            r_flush       <= w_flush_next;
            r_fetch_valid <= w_fetch_valid_next;
            r_halted      <= (w_state_next == HALTED);
        end
    end

    assign o_PC          = r_pc;
    assign o_PC_plus4    = r_pc_plus4;
    assign o_flush       = r_flush;
    assign o_fetch_valid = r_fetch_valid;
    assign o_halted      = r_halted;

`ifdef PC_CYCLE_COUNT_EN
    logic [31:0] r_cycle_count;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)                           r_cycle_count <= '0;
        else if (w_advance && r_cycle_count != '1) r_cycle_count <= r_cycle_count + 32'd1;
    end
    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif
endmodule

// File: tb/tb_pc_fetch_control.sv
// tb_pc_fetch_control: vector table, directed corner sequences and randomized
// run against a behavioural model of pc_fetch_control.
module tb_pc_fetch_control;
`ifdef PC_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start, mode, step, stall, br, jmp, halt;
    logic [31:0] bt, jt;
    logic [31:0] pc, pc4, cnt;
    logic        fv, fl, hlt;
    int          n_chk = 0, n_fail = 0;

    int          m_st;
    longint      m_pc, m_cnt;
    bit          m_fl, m_fv;

    typedef struct {
        bit start, mode, step, stall, br, jmp, halt;
        logic [31:0] bt, jt, e_pc;
        bit e_fv, e_fl, e_h;
    } vec_t;
    vec_t tbl[9];

    pc_fetch_control dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_mode_step(mode),
        .i_step(step), .i_stall(stall), .i_branch_taken(br), .i_branch_target(bt),
        .i_jump(jmp), .i_jump_target(jt), .i_halt(halt), .o_PC(pc),
        .o_PC_plus4(pc4), .o_fetch_valid(fv), .o_flush(fl), .o_halted(hlt),
        .o_cycle_count(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        start = 0; mode = 0; step = 0; stall = 0; br = 0; jmp = 0; halt = 0; bt = 0; jt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_in();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_st = 0; m_pc = 0; m_cnt = 0; m_fl = 0; m_fv = 0;
    endtask

    function automatic vec_t v(bit s, bit md, bit sp, bit st, bit b, bit j, bit h,
                               int tb_, int tj, int epc, bit efv, bit efl, bit eh);
        vec_t r;
        r.start = s; r.mode = md; r.step = sp; r.stall = st; r.br = b; r.jmp = j; r.halt = h;
        r.bt = tb_; r.jt = tj; r.e_pc = epc; r.e_fv = efv; r.e_fl = efl; r.e_h = eh;
        return r;
    endfunction

    // Model: modes 0 idle, 1 run, 2 step-wait, 3 halted
    function automatic void model_step();
        longint nxt;
        bit held;
        held = 0;
        if (m_st == 0) begin
            m_fl = 0;
            m_fv = start && !mode;
            if (start) m_st = mode ? 2 : 1;
        end else if (m_st == 3 || (m_st == 2 && !step)) begin
            m_fl = 0;
            m_fv = 0;
        end else begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (halt) begin
                m_st = 3; m_fl = 1; m_fv = 0;
            end else begin
                if (br)         begin nxt = bt; m_fl = 1; end
                else if (stall) begin nxt = m_pc; m_fl = 0; held = 1; end
                else if (jmp)   begin nxt = jt; m_fl = 1; end
                else            begin nxt = (m_pc + 4) % (64'd1 << 32); m_fl = 0; end
                if (nxt >= 60 || nxt % 4 != 0) begin
                    m_st = 3; m_fv = 0;
                end else begin
                    m_pc = nxt; m_fv = !held;
                end
            end
        end
    endfunction

    task automatic check_model(string name);
        logic [31:0] e_pc, e_pc4, e_cnt;
        e_pc  = m_pc[31:0];
        e_pc4 = 32'(m_pc + 4);
        e_cnt = CNT_EN ? m_cnt[31:0] : 32'd0;
        check(name, {pc, pc4, fv, fl, hlt, cnt}, {e_pc, e_pc4, m_fv, m_fl, m_st == 3, e_cnt});
    endtask

    function automatic logic [31:0] rnd_tgt();
        int r;
        r = $urandom_range(15);
        if (r == 0) return $urandom;
        if (r == 1) return 32'(4 * $urandom_range(14) + 2);
        return 32'(4 * $urandom_range(14));
    endfunction

    initial begin
        tbl[0] = v(1,0,0,0,0,0,0,  0,  0,  0, 1, 0, 0);
        tbl[1] = v(0,0,0,0,0,0,0,  0,  0,  4, 1, 0, 0);
        tbl[2] = v(0,0,0,0,0,0,0,  0,  0,  8, 1, 0, 0);
        tbl[3] = v(0,0,0,0,1,1,0, 52, 20, 52, 1, 1, 0);
        tbl[4] = v(0,0,0,0,0,0,0,  0,  0, 56, 1, 0, 0);
        tbl[5] = v(0,0,0,0,0,0,0,  0,  0, 56, 0, 0, 1);
        tbl[6] = v(0,0,0,0,0,0,1,  0,  0, 56, 0, 0, 1);
        tbl[7] = v(0,0,0,0,0,1,0,  0,  8, 56, 0, 0, 1);
        tbl[8] = v(0,0,1,0,0,0,0,  0,  0, 56, 0, 0, 1);

        do_reset();
        check("reset", {pc, pc4, fv, fl, hlt, cnt}, {32'd0, 32'd4, 3'b000, 32'd0});

        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start; mode = tbl[i].mode; step = tbl[i].step; stall = tbl[i].stall;
            br = tbl[i].br; jmp = tbl[i].jmp; halt = tbl[i].halt; bt = tbl[i].bt; jt = tbl[i].jt;
            tick();
            check($sformatf("vec%0d", i), {pc, fv, fl, hlt},
                  {tbl[i].e_pc, tbl[i].e_fv, tbl[i].e_fl, tbl[i].e_h});
        end
        check("vec_count", cnt, CNT_EN ? 32'd5 : 32'd0);

        do_reset();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) tick();
        check("stall_pre", pc, 32'd12);
        stall = 1;
        tick(); check("stall_1", {pc, fv, fl}, {32'd12, 2'b00});
        tick(); check("stall_2", {pc, fv, fl}, {32'd12, 2'b00});
        stall = 0;
        tick(); check("stall_rel", {pc, fv, fl}, {32'd16, 2'b10});

        do_reset();
        start = 1; mode = 1; tick(); start = 0; mode = 0;
        check("step_enter", {pc, fv, hlt}, {32'd0, 2'b00});
        for (int k = 1; k <= 3; k++) begin
            step = 1; tick(); step = 0;
            check($sformatf("step%0d", k), {pc, fv}, {32'(4 * k), 1'b1});
            for (int i = 0; i < 3; i++) tick();
            check($sformatf("step%0d_hold", k), {pc, fv}, {32'(4 * k), 1'b0});
        end
        check("step_count", cnt, CNT_EN ? 32'd3 : 32'd0);

        do_reset();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 8; i++) tick();
        check("arst_pre", pc, 32'd32);
        #2 rst_n = 1'b0;
        #1 check("arst_now", {pc, fv, fl, hlt, cnt}, {32'd0, 3'b000, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_idle", {pc, fv}, {32'd0, 1'b0});

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(3) == 0); mode = 1'($urandom_range(1));
            step = ($urandom_range(2) == 0); stall = ($urandom_range(5) == 0);
            br = ($urandom_range(7) == 0); jmp = ($urandom_range(5) == 0);
            halt = ($urandom_range(40) == 0); bt = rnd_tgt(); jt = rnd_tgt();
            model_step();
            tick();
            check_model($sformatf("rand%0d", c));
            if (m_st == 3 && $urandom_range(3) == 0) begin
                do_reset();
                check_model($sformatf("rand%0d_rst", c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
